// File: rtl/move_arbiter_pkg.sv
// Shared op codes and FSM state encoding for the move arbiter and its
// pending-request tracker.
package move_arbiter_pkg;

    typedef logic [1:0] op_t;

    localparam op_t OP_GRAV  = 2'b00;
    localparam op_t OP_ROT   = 2'b01;
    localparam op_t OP_LEFT  = 2'b10;
    localparam op_t OP_RIGHT = 2'b11;

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        WAIT,
        COMMIT,
        LOCK
    } state_t;

endpackage

// File: rtl/move_arbiter_if.sv
// Handshake bundle between the move arbiter and the shared collision checker.
interface move_arbiter_if;
    import move_arbiter_pkg::*;

    logic chk_valid;
    op_t  chk_op;
    logic chk_ready;
    logic chk_done;
    logic chk_ok;

    modport master (
        output chk_valid,
        output chk_op,
        input  chk_ready,
        input  chk_done,
        input  chk_ok
    );

    modport slave (
        input  chk_valid,
        input  chk_op,
        output chk_ready,
        output chk_done,
        output chk_ok
    );

endinterface

// File: rtl/move_pending.sv
// Pending move/gravity flags with merge detection and the fixed-priority plus
// left/right round-robin winner selection.
module move_pending
    import move_arbiter_pkg::*;
(
    input  logic       clk,
    input  logic       resetn,
    input  logic       enable,
    input  logic       tick_gravity,
    input  logic       rot_final,
    input  logic       left_final,
    input  logic       right_final,
    input  logic       grant,
    output logic       any_pend,
    output op_t        win_op,
    output logic [2:0] merge_n
);

    logic p_grav, p_rot, p_left, p_right;
    logic rr_right;
    logic e_grav, e_rot, e_left, e_right;
    logic g_grav, g_rot, g_left, g_right;
    logic m_grav, m_rot, m_left, m_right;

    // A pulse in the same cycle as its grant survives only if it is not the one being granted.
    function automatic logic next_flag(input logic flag, input logic pulse, input logic gnt);
        return gnt ? (flag & pulse) : (flag | pulse);
    endfunction

    always_comb begin
        e_grav   = enable & (p_grav  | tick_gravity);
        e_rot    = enable & (p_rot   | rot_final);
        e_left   = enable & (p_left  | left_final);
        e_right  = enable & (p_right | right_final);
        any_pend = e_grav | e_rot | e_left | e_right;
        if (e_grav)
            win_op = OP_GRAV;
        else if (e_rot)
            win_op = OP_ROT;
        else if (e_left && (!e_right || rr_right))
            win_op = OP_LEFT;
        else
            win_op = OP_RIGHT;
    end

    assign g_grav  = grant && (win_op == OP_GRAV);
    assign g_rot   = grant && (win_op == OP_ROT);
    assign g_left  = grant && (win_op == OP_LEFT);
    assign g_right = grant && (win_op == OP_RIGHT);

    assign m_grav  = enable & tick_gravity & p_grav  & ~g_grav;
    assign m_rot   = enable & rot_final    & p_rot   & ~g_rot;
    assign m_left  = enable & left_final   & p_left  & ~g_left;
    assign m_right = enable & right_final  & p_right & ~g_right;
    assign merge_n = 3'(m_grav) + 3'(m_rot) + 3'(m_left) + 3'(m_right);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            p_grav   <= 1'b0;
            p_rot    <= 1'b0;
            p_left   <= 1'b0;
            p_right  <= 1'b0;
            rr_right <= 1'b1;
        end else if (!enable) begin
            p_grav   <= 1'b0;
            p_rot    <= 1'b0;
            p_left   <= 1'b0;
            p_right  <= 1'b0;
        end else begin
            p_grav  <= next_flag(p_grav,  tick_gravity, g_grav);
            p_rot   <= next_flag(p_rot,   rot_final,    g_rot);
            p_left  <= next_flag(p_left,  left_final,   g_left);
            p_right <= next_flag(p_right, right_final,  g_right);
            if (g_left)
                rr_right <= 1'b0;
            else if (g_right)
                rr_right <= 1'b1;
        end
    end

endmodule

// File: rtl/move_arbiter.sv
// Serialises pending moves and gravity ticks onto the single collision-check
// handshake and turns each result into a one-cycle commit or lock pulse.
module move_arbiter
    import move_arbiter_pkg::*;
#(
    parameter int TIMEOUT = 64,
    parameter int CNT_W   = 8
) (
    input  logic             CLOCK_50,
    input  logic             resetn,
    input  logic             enable,
    input  logic             left_final,
    input  logic             right_final,
    input  logic             rot_final,
    input  logic             tick_gravity,
    move_arbiter_if.master   chk,
    output logic             commit,
    output op_t              commit_op,
    output logic             lock,
    output logic             busy,
    output logic             timeout_err,
    output logic [CNT_W-1:0] drop_cnt
);

    localparam int WCNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    state_t            state;
    logic [WCNT_W-1:0] wcnt;
    logic              grant;
    logic              any_pend;
    logic              to_hit;
    op_t               win_op;
    logic [2:0]        merge_n;
    logic [3:0]        drop_inc;

    function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a, input logic [3:0] b);
        logic [CNT_W:0] s;
        s = {1'b0, a} + (CNT_W+1)'(b);
        return s[CNT_W] ? {CNT_W{1'b1}} : s[CNT_W-1:0];
    endfunction

    move_pending u_pending (
        .clk          (CLOCK_50),
        .resetn       (resetn),
        .enable       (enable),
        .tick_gravity (tick_gravity),
        .rot_final    (rot_final),
        .left_final   (left_final),
        .right_final  (right_final),
        .grant        (grant),
        .any_pend     (any_pend),
        .win_op       (win_op),
        .merge_n      (merge_n)
    );

    assign grant    = (state == IDLE) && enable && any_pend;
    assign to_hit   = (state == WAIT) && !chk.chk_done && (wcnt == WCNT_W'(TIMEOUT - 1));
    assign drop_inc = {1'b0, merge_n} + {3'b000, to_hit};

    // chk_op doubles as the latched op for the whole transaction.
    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            state         <= IDLE;
            chk.chk_valid <= 1'b0;
            chk.chk_op    <= OP_GRAV;
            commit        <= 1'b0;
            commit_op     <= OP_GRAV;
            lock          <= 1'b0;
            busy          <= 1'b0;
            timeout_err   <= 1'b0;
            wcnt          <= '0;
        end else begin
            commit <= 1'b0;
            lock   <= 1'b0;
            case (state)
                IDLE: begin
                    if (grant) begin
                        state         <= REQ;
                        chk.chk_valid <= 1'b1;
                        chk.chk_op    <= win_op;
                        busy          <= 1'b1;
                    end
                end
                REQ: begin
                    if (!enable) begin
                        state         <= IDLE;
                        chk.chk_valid <= 1'b0;
                        busy          <= 1'b0;
                    end else if (chk.chk_ready) begin
                        state         <= WAIT;
                        chk.chk_valid <= 1'b0;
                        wcnt          <= '0;
                    end
                end
                WAIT: begin
                    if (chk.chk_done) begin
                        if (chk.chk_ok) begin
                            state     <= COMMIT;
                            commit    <= 1'b1;
                            commit_op <= chk.chk_op;
                        end else if (chk.chk_op == OP_GRAV) begin
                            state <= LOCK;
                            lock  <= 1'b1;
                        end else begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end
                    end else if (to_hit) begin
                        state       <= IDLE;
                        busy        <= 1'b0;
                        timeout_err <= 1'b1;
                    end else begin
                        wcnt <= wcnt + WCNT_W'(1);
                    end
                end
                COMMIT, LOCK: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state         <= IDLE;
                    busy          <= 1'b0;
                    chk.chk_valid <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn)
            drop_cnt <= '0;
        else
            drop_cnt <= sat_add(drop_cnt, drop_inc);
    end

endmodule

// File: tb/tb_move_arbiter.sv
// Directed and randomised bench for move_arbiter; the bench plays the
// collision checker and predicts grants from an op-level pending-set model.
module tb_move_arbiter;
    import move_arbiter_pkg::*;

    logic       CLOCK_50 = 1'b0;
    logic       resetn = 1'b0;
    logic       enable = 1'b0;
    logic       left_final = 1'b0;
    logic       right_final = 1'b0;
    logic       rot_final = 1'b0;
    logic       tick_gravity = 1'b0;
    logic       commit;
    op_t        commit_op;
    logic       lock;
    logic       busy;
    logic       timeout_err;
    logic [7:0] drop_cnt;

    int checks = 0;
    int errors = 0;

    move_arbiter_if chk_if ();

    move_arbiter #(.TIMEOUT(64), .CNT_W(8)) dut (
        .CLOCK_50     (CLOCK_50),
        .resetn       (resetn),
        .enable       (enable),
        .left_final   (left_final),
        .right_final  (right_final),
        .rot_final    (rot_final),
        .tick_gravity (tick_gravity),
        .chk          (chk_if),
        .commit       (commit),
        .commit_op    (commit_op),
        .lock         (lock),
        .busy         (busy),
        .timeout_err  (timeout_err),
        .drop_cnt     (drop_cnt)
    );

    always #10 CLOCK_50 = ~CLOCK_50;

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(negedge CLOCK_50);
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic pulse(input logic g, input logic r, input logic l, input logic rt);
        tick_gravity = g;
        rot_final    = r;
        left_final   = l;
        right_final  = rt;
        tick();
        tick_gravity = 1'b0;
        rot_final    = 1'b0;
        left_final   = 1'b0;
        right_final  = 1'b0;
    endtask

    task automatic do_reset();
        resetn = 1'b0;
        repeat (2) tick();
        resetn = 1'b1;
        tick();
    endtask

    // Waits for a request (chk_ready assumed high), answers after dly WAIT cycles.
    task automatic serve(input op_t exp_op, input logic ok, input int dly);
        int n = 0;
        while (!chk_if.chk_valid && n < 16) begin
            tick();
            n++;
        end
        check("req_valid", chk_if.chk_valid, 1);
        check("req_op", chk_if.chk_op, exp_op);
        tick();
        check("wait_valid_low", chk_if.chk_valid, 0);
        repeat (dly) tick();
        chk_if.chk_done = 1'b1;
        chk_if.chk_ok   = ok;
        tick();
        chk_if.chk_done = 1'b0;
        chk_if.chk_ok   = 1'b0;
        check("commit", commit, ok);
        check("lock", lock, (!ok && exp_op == OP_GRAV));
        if (ok) check("commit_op", commit_op, exp_op);
        tick();
        check("pulse_one_cycle", {commit, lock}, 0);
    endtask

    // Op-level reference state for the randomised phase
    bit   pend [4];
    int   mdrop;
    bit   last_right;
    op_t  cur_op;
    op_t  exp_op;
    int   wleft;
    bit   in_wait, res_due, exp_c, exp_l, prev_valid, active, drained, pend_any;
    logic okv;

    function automatic op_t model_pick();
        if (pend[0]) return OP_GRAV;
        if (pend[1]) return OP_ROT;
        if (pend[2] && pend[3]) return last_right ? OP_LEFT : OP_RIGHT;
        if (pend[2]) return OP_LEFT;
        return OP_RIGHT;
    endfunction

    initial begin
        chk_if.chk_ready = 1'b0;
        chk_if.chk_done  = 1'b0;
        chk_if.chk_ok    = 1'b0;
        tick();
        check("rst_chk_valid", chk_if.chk_valid, 0);
        check("rst_chk_op", chk_if.chk_op, 0);
        check("rst_commit", commit, 0);
        check("rst_commit_op", commit_op, 0);
        check("rst_lock", lock, 0);
        check("rst_busy", busy, 0);
        check("rst_timeout", timeout_err, 0);
        check("rst_drop", drop_cnt, 0);
        resetn = 1'b1;
        enable = 1'b1;
        chk_if.chk_ready = 1'b1;
        tick();

        // Single left move, result two cycles after accept
        pulse(0, 0, 1, 0);
        check("left_latency_valid", chk_if.chk_valid, 1);
        serve(OP_LEFT, 1'b1, 2);
        check("left_busy_done", busy, 0);

        // Simultaneous gravity/rotate/left resolve by priority
        pulse(1, 1, 1, 0);
        serve(OP_GRAV, 1'b1, 0);
        serve(OP_ROT, 1'b1, 1);
        serve(OP_LEFT, 1'b1, 0);
        check("prio_drop", drop_cnt, 0);

        // Round-robin from the reset value
        do_reset();
        pulse(0, 0, 1, 1);
        serve(OP_LEFT, 1'b1, 0);
        serve(OP_RIGHT, 1'b1, 0);
        pulse(0, 0, 1, 1);
        serve(OP_LEFT, 1'b1, 1);
        serve(OP_RIGHT, 1'b1, 0);

        // Rejected results
        pulse(1, 0, 0, 0);
        serve(OP_GRAV, 1'b0, 1);
        pulse(0, 1, 0, 0);
        serve(OP_ROT, 1'b0, 1);
        check("reject_busy", busy, 0);

        // Timeout with chk_done held low
        pulse(0, 0, 0, 1);
        check("to_req", chk_if.chk_valid, 1);
        tick();
        repeat (63) tick();
        check("to_not_yet", timeout_err, 0);
        check("to_busy_yet", busy, 1);
        tick();
        check("to_err", timeout_err, 1);
        check("to_idle", busy, 0);
        check("to_drop", drop_cnt, 1);
        pulse(0, 0, 1, 0);
        serve(OP_LEFT, 1'b1, 2);
        check("to_sticky", timeout_err, 1);

        // Merged left pulses while a rotate request is held
        chk_if.chk_ready = 1'b0;
        pulse(0, 1, 0, 0);
        pulse(0, 0, 1, 0);
        pulse(0, 0, 1, 0);
        check("merge_drop", drop_cnt, 2);
        check("merge_op_stable", chk_if.chk_op, OP_ROT);
        check("merge_valid_held", chk_if.chk_valid, 1);
        chk_if.chk_ready = 1'b1;
        serve(OP_ROT, 1'b1, 1);
        serve(OP_LEFT, 1'b1, 1);
        repeat (4) tick();
        check("merge_no_extra", chk_if.chk_valid, 0);
        check("merge_idle", busy, 0);

        // Disabled: pulses ignored, REQ aborts, WAIT completes
        enable = 1'b0;
        pulse(0, 0, 1, 0);
        check("dis_no_grant", chk_if.chk_valid, 0);
        tick();
        check("dis_no_count", drop_cnt, 2);
        enable = 1'b1;
        chk_if.chk_ready = 1'b0;
        pulse(1, 0, 0, 0);
        pulse(0, 1, 0, 0);
        enable = 1'b0;
        tick();
        check("abort_idle", busy, 0);
        check("abort_valid", chk_if.chk_valid, 0);
        enable = 1'b1;
        repeat (3) tick();
        check("abort_flushed", chk_if.chk_valid, 0);
        chk_if.chk_ready = 1'b1;
        pulse(0, 0, 1, 0);
        tick();
        enable = 1'b0;
        chk_if.chk_done = 1'b1;
        chk_if.chk_ok   = 1'b1;
        tick();
        chk_if.chk_done = 1'b0;
        chk_if.chk_ok   = 1'b0;
        check("dis_inflight_commit", commit, 1);
        enable = 1'b1;
        tick();
        chk_if.chk_done = 1'b1;
        chk_if.chk_ok   = 1'b1;
        tick();
        chk_if.chk_done = 1'b0;
        chk_if.chk_ok   = 1'b0;
        check("stray_done_commit", commit, 0);
        check("stray_done_busy", busy, 0);

        // Asynchronous reset in the middle of WAIT
        pulse(0, 0, 1, 0);
        tick();
        check("arst_in_wait", busy, 1);
        #5 resetn = 1'b0;
        #1;
        check("arst_busy", busy, 0);
        check("arst_timeout", timeout_err, 0);
        check("arst_drop", drop_cnt, 0);
        check("arst_commit_op", commit_op, 0);
        check("arst_chk_op", chk_if.chk_op, 0);
        tick();
        resetn = 1'b1;
        tick();

        // Randomised traffic against the pending-set model
        foreach (pend[i]) pend[i] = 1'b0;
        mdrop = 0;
        last_right = 1'b1;
        in_wait = 0;
        res_due = 0;
        prev_valid = 0;
        drained = 0;
        cur_op = OP_GRAV;
        for (int cyc = 0; cyc < 2500; cyc++) begin
            active = (cyc < 1500);
            tick();
            tick_gravity = 1'b0;
            rot_final = 1'b0;
            left_final = 1'b0;
            right_final = 1'b0;
            chk_if.chk_done = 1'b0;
            chk_if.chk_ok = 1'b0;
            chk_if.chk_ready = 1'b0;
            if (res_due) begin
                check("rnd_commit", commit, exp_c);
                check("rnd_lock", lock, exp_l);
                if (exp_c) check("rnd_commit_op", commit_op, cur_op);
                res_due = 0;
            end else begin
                check("rnd_quiet", {commit, lock}, 0);
            end
            if (in_wait) begin
                if (wleft == 0) begin
                    okv = 1'($urandom_range(0, 1));
                    chk_if.chk_done = 1'b1;
                    chk_if.chk_ok = okv;
                    exp_c = okv;
                    exp_l = !okv && (cur_op == OP_GRAV);
                    res_due = 1;
                    in_wait = 0;
                end else begin
                    wleft--;
                end
            end else if (chk_if.chk_valid) begin
                if (!prev_valid) begin
                    exp_op = model_pick();
                    check("rnd_op", chk_if.chk_op, exp_op);
                    cur_op = exp_op;
                    pend[exp_op] = 1'b0;
                    if (exp_op == OP_LEFT) last_right = 1'b0;
                    if (exp_op == OP_RIGHT) last_right = 1'b1;
                end
                chk_if.chk_ready = 1'($urandom_range(0, 1));
                if (chk_if.chk_ready) begin
                    in_wait = 1;
                    wleft = $urandom_range(0, 3);
                end
            end
            prev_valid = chk_if.chk_valid;
            pend_any = pend[0] | pend[1] | pend[2] | pend[3];
            if (active && (busy || !pend_any)) begin
                for (int o = 0; o < 4; o++) begin
                    if ($urandom_range(0, 7) == 0) begin
                        case (o)
                            0: tick_gravity = 1'b1;
                            1: rot_final = 1'b1;
                            2: left_final = 1'b1;
                            default: right_final = 1'b1;
                        endcase
                        if (pend[o]) begin
                            if (mdrop < 255) mdrop++;
                        end else begin
                            pend[o] = 1'b1;
                        end
                    end
                end
            end
            if (!active && !busy && !pend_any && !in_wait && !res_due) begin
                drained = 1;
                break;
            end
        end
        check("rnd_drained", drained, 1);
        check("rnd_drop", drop_cnt, mdrop);
        check("rnd_no_timeout", timeout_err, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/move_arbiter.md
Name: move_arbiter

Overview:
- Sits between the input-conditioning front end and the game FSM's single shared collision-check/board-update resource.
- Latches the one-shot move requests (rotate, left, right) and the gravity tick into pending flags.
- Serialises them onto one collision-checker handshake, then emits a one-cycle commit or lock pulse for the result.
- Guarantees at most one outstanding check, no lost gravity ticks, and no starvation between left and right.

Parameters:
TIMEOUT  64  cycles to wait for chk_done before aborting the request
CNT_W    8   width of the saturating dropped-event counter

Ports:
CLOCK_50      in   1      system clock, 50 MHz
resetn        in   1      reset, asynchronous, active-low
enable        in   1      game running; low = flush pending flags and hold IDLE
left_final    in   1      1-cycle left request pulse
right_final   in   1      1-cycle right request pulse
rot_final     in   1      1-cycle rotate request pulse
tick_gravity  in   1      1-cycle gravity step pulse
chk_valid     out  1      request to collision checker
chk_op        out  2      op code: 00 gravity, 01 rotate, 10 left, 11 right
chk_ready     in   1      checker accepts request this cycle
chk_done      in   1      1-cycle result strobe
chk_ok        in   1      result, valid with chk_done: 1 = move legal
commit        out  1      1-cycle pulse: apply commit_op to the piece
commit_op     out  2      op being committed; valid with commit
lock          out  1      1-cycle pulse: gravity blocked, lock the piece
busy          out  1      high whenever state != IDLE
timeout_err   out  1      sticky, set on timeout, cleared only by reset
drop_cnt      out  CNT_W  saturating count of merged or discarded events

Behaviour:
- Reset (async, resetn=0) values:
  - state=IDLE; all pending flags 0; rr_last=RIGHT.
  - chk_valid, commit, lock, busy, timeout_err all 0.
  - chk_op=00, commit_op=00, drop_cnt=0.
- Pending flags: p_grav, p_rot, p_left, p_right.
  - Each is set on its input pulse and cleared when its op is granted.
  - A pulse arriving while its flag is already 1 is merged and increments drop_cnt (saturating at all-ones).
  - A pulse arriving in the same cycle the flag is granted re-sets the flag, so it is not lost.
- Priority at grant:
  - p_grav beats p_rot, which beats the left/right pair.
  - Left vs right is round-robin: when both are pending, grant the one that was not granted last (rr_last). rr_last updates on grant only.
- FSM:
  - IDLE: if enable and any flag is set, grant the winner, latch its op, go to REQ (one cycle after the pulse at the earliest).
  - REQ: chk_valid=1, chk_op stable. When chk_ready=1, go to WAIT. chk_op must not change while chk_valid=1.
  - WAIT: chk_valid=0; wait counter counts up.
    - chk_done=1 with chk_ok=1: go to COMMIT.
    - chk_done=1 with chk_ok=0 and op=gravity: go to LOCK.
    - chk_done=1 with chk_ok=0 and any other op: go to IDLE silently (illegal move rejected).
    - Counter reaches TIMEOUT-1 without chk_done: set timeout_err, drop the op (drop_cnt+1), go to IDLE.
  - COMMIT: commit=1 and commit_op=latched op for exactly one cycle, then IDLE.
  - LOCK: lock=1 for exactly one cycle, then IDLE.
- Latency: pulse at cycle N with arbiter idle and chk_ready held high:
  - chk_valid at N+1; WAIT at N+2.
  - chk_done at N+k gives commit/lock at N+k+1.
- enable=0:
  - All flags clear immediately.
  - Incoming pulses are ignored and not counted.
  - REQ aborts to IDLE.
  - An in-flight WAIT completes normally; its commit/lock still fires.
  - No new grants while enable=0.
- chk_done outside WAIT is ignored.
- The wait counter is ceil(log2(TIMEOUT)) bits and clears on entry to WAIT.

Decomposition:
- Shared package holds:
  - op-code constants OP_GRAV=2'b00, OP_ROT=2'b01, OP_LEFT=2'b10, OP_RIGHT=2'b11;
  - state encodings IDLE, REQ, WAIT, COMMIT, LOCK.
- One sub-module is natural: move_pending, which holds the four flags, the merge/drop detection and the priority plus round-robin grant logic.
- The FSM, wait counter and output registers stay in move_arbiter.

Test Plan:
- Single left pulse, chk_ready=1, chk_done two cycles after accept with chk_ok=1 → chk_valid with chk_op=10 for one cycle, then commit=1 with commit_op=10 for exactly one cycle; busy returns to 0.
- Gravity, rotate and left pulsed in the same cycle, every check ok → commits in order 00, 01, 10; drop_cnt stays 0.
- Left and right pending together three times → grants alternate left, right, left (from the reset value rr_last=RIGHT).
- Gravity check returns chk_ok=0 → lock=1 for one cycle, commit stays 0. Rotate check returns chk_ok=0 → neither commit nor lock fires.
- Hold chk_done low for 64 cycles in WAIT → timeout_err=1 (sticky), drop_cnt=1, state returns to IDLE; a later request is still serviced.
- Two left pulses while busy → drop_cnt=1 and exactly one extra left commit. resetn asserted mid-WAIT → all outputs reach reset values immediately, asynchronously.
